// File: rtl/instr_result_checker.sv
// Re-executes a span of instruction-file entries and scores each stored result against a recomputed one.
// Two cycles per entry, done 2N+2 cycles after start (2 for N=0); no backpressure, start ignored unless idle.
module instr_result_checker (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  first_ptr,
  input  logic [5:0]  num_entries,
  output logic [4:0]  read_pointer,
  input  logic [3:0]  iw_opc,
  input  logic [31:0] iw_op_a,
  input  logic [31:0] iw_op_b,
  input  logic [63:0] iw_result,
  output logic        busy,
  output logic        done,
  output logic [5:0]  pass_count,
  output logic [5:0]  fail_count,
  output logic        err_valid,
  output logic [4:0]  err_ptr,
  output logic [63:0] err_expected
);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, FINISH} state_t;

  state_t state, state_nxt;

  logic [5:0]         remaining;
  logic [5:0]         num_clamped;
  logic [3:0]         cap_opc;
  logic [31:0]        cap_a;
  logic [31:0]        cap_b;
  logic [63:0]        cap_result;
  logic               accept;
  logic               capture;
  logic               compare;
  logic               finish;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] expected;
  logic               opc_valid;
  logic               match;

  assign num_clamped = (num_entries > 6'd32) ? 6'd32 : num_entries;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    compare   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_clamped == 6'd0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        capture   = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        compare   = 1'b1;
        state_nxt = (remaining == 6'd1) ? FINISH : FETCH;
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is evaluated at 64 bits so MULT is exact and MIN_INT / -1 cannot overflow.
  assign a_ext = {{32{cap_a[31]}}, cap_a};
  assign b_ext = {{32{cap_b[31]}}, cap_b};

  always_comb begin
    expected  = '0;
    opc_valid = 1'b1;
    case (cap_opc)
      4'd0: expected = '0;
      4'd1: expected = a_ext;
      4'd2: expected = b_ext;
      4'd3: expected = a_ext + b_ext;
      4'd4: expected = a_ext - b_ext;
      4'd5: expected = a_ext * b_ext;
      4'd6: if (cap_b != '0) expected = a_ext / b_ext;
      4'd7: if (cap_b != '0) expected = a_ext % b_ext;
      default: opc_valid = 1'b0;
    endcase
  end

  assign match = opc_valid && (expected == cap_result);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass_count   <= '0;
      fail_count   <= '0;
      err_valid    <= 1'b0;
      err_ptr      <= '0;
      err_expected <= '0;
      cap_opc      <= '0;
      cap_a        <= '0;
      cap_b        <= '0;
      cap_result   <= '0;
    end else begin
      done      <= finish;
      err_valid <= 1'b0;
      if (accept) begin
        read_pointer <= first_ptr;
        remaining    <= num_clamped;
        pass_count   <= '0;
        fail_count   <= '0;
        busy         <= 1'b1;
      end
      if (capture) begin
        cap_opc    <= iw_opc;
        cap_a      <= iw_op_a;
        cap_b      <= iw_op_b;
        cap_result <= iw_result;
      end
      if (compare) begin
        read_pointer <= read_pointer + 5'd1;
        remaining    <= remaining - 6'd1;
        if (match) begin
          if (pass_count != 6'd63) pass_count <= pass_count + 6'd1;
        end else begin
          if (fail_count != 6'd63) fail_count <= fail_count + 6'd1;
          err_valid    <= 1'b1;
          err_ptr      <= read_pointer;
          err_expected <= expected;
        end
      end
      if (finish) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_result_checker.sv
// Directed and randomized runs of instr_result_checker against an arithmetic reference model.
module tb_instr_result_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_ptr = '0;
  logic [5:0]  num_entries = '0;
  logic [4:0]  read_pointer;
  logic [3:0]  iw_opc;
  logic [31:0] iw_op_a;
  logic [31:0] iw_op_b;
  logic [63:0] iw_result;
  logic        busy;
  logic        done;
  logic [5:0]  pass_count;
  logic [5:0]  fail_count;
  logic        err_valid;
  logic [4:0]  err_ptr;
  logic [63:0] err_expected;

  logic [3:0]  m_opc [32];
  logic [31:0] m_a   [32];
  logic [31:0] m_b   [32];
  logic [63:0] m_res [32];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign iw_opc    = m_opc[read_pointer];
  assign iw_op_a   = m_a[read_pointer];
  assign iw_op_b   = m_b[read_pointer];
  assign iw_result = m_res[read_pointer];

  instr_result_checker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_ptr(first_ptr),
    .num_entries(num_entries), .read_pointer(read_pointer), .iw_opc(iw_opc),
    .iw_op_a(iw_op_a), .iw_op_b(iw_op_b), .iw_result(iw_result), .busy(busy),
    .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .err_valid(err_valid), .err_ptr(err_ptr), .err_expected(err_expected)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic longint ref_value(input logic [3:0] opc, input logic [31:0] a_bits,
                                       input logic [31:0] b_bits);
    longint a, b;
    a = longint'($signed(a_bits));
    b = longint'($signed(b_bits));
    case (opc)
      4'd0: return 0;
      4'd1: return a;
      4'd2: return b;
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return a * b;
      4'd6: return (b == 0) ? 0 : a / b;
      4'd7: return (b == 0) ? 0 : a - (a / b) * b;
      default: return 0;
    endcase
  endfunction

  task automatic set_entry(input int p, input int opc, input int a, input int b, input longint res);
    m_opc[p] = 4'(opc);
    m_a[p]   = a;
    m_b[p]   = b;
    m_res[p] = res;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " read_pointer"}, read_pointer, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err_valid"}, err_valid, 0);
    check({tag, " pass_count"}, pass_count, 0);
    check({tag, " fail_count"}, fail_count, 0);
    check({tag, " err_ptr"}, err_ptr, 0);
    check({tag, " err_expected"}, err_expected, 0);
  endtask

  task automatic run(input string tag, input int first, input int num, input bit glitch);
    int n, p, exp_pass, exp_fail, done_cyc;
    logic [4:0]  exp_ptr_q[$], ptr_q[$], rp_q[$];
    logic [63:0] exp_val_q[$], val_q[$];
    int          exp_cyc_q[$], cyc_q[$];
    n = (num > 32) ? 32 : num;
    exp_pass = 0;
    exp_fail = 0;
    for (int i = 0; i < n; i++) begin
      longint e;
      p = (first + i) % 32;
      e = (m_opc[p] > 4'd7) ? 0 : ref_value(m_opc[p], m_a[p], m_b[p]);
      if (m_opc[p] <= 4'd7 && e == longint'(m_res[p])) exp_pass++;
      else begin
        exp_fail++;
        exp_ptr_q.push_back(p[4:0]);
        exp_val_q.push_back(e);
        exp_cyc_q.push_back(2 * i + 3);
      end
    end

    @(negedge clk);
    start = 1'b1;
    first_ptr = first[4:0];
    num_entries = num[5:0];
    done_cyc = -1;
    for (int cyc = 1; cyc <= 2 * n + 10; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, " busy"}, busy, 1);
      end
      if (glitch && cyc == 3) begin
        start = 1'b1;
        first_ptr = 5'd7;
        num_entries = 6'd5;
      end
      if (glitch && cyc == 4) start = 1'b0;
      if (cyc % 2 == 1 && cyc < 2 * n) rp_q.push_back(read_pointer);
      if (err_valid) begin
        ptr_q.push_back(err_ptr);
        val_q.push_back(err_expected);
        cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        check({tag, " busy at done"}, busy, 0);
        check({tag, " pass_count"}, pass_count, 6'(exp_pass));
        check({tag, " fail_count"}, fail_count, 6'(exp_fail));
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, done, 0);
        check({tag, " pass_count hold"}, pass_count, 6'(exp_pass));
        check({tag, " fail_count hold"}, fail_count, 6'(exp_fail));
        break;
      end
    end
    check({tag, " done cycle"}, done_cyc, 2 * n + 2);
    check({tag, " read count"}, rp_q.size(), n);
    for (int i = 0; i < n && i < rp_q.size(); i++)
      check({tag, " read_pointer"}, rp_q[i], (first + i) % 32);
    check({tag, " err count"}, ptr_q.size(), exp_ptr_q.size());
    for (int i = 0; i < exp_ptr_q.size() && i < ptr_q.size(); i++) begin
      check({tag, " err_ptr"}, ptr_q[i], exp_ptr_q[i]);
      check({tag, " err_expected"}, val_q[i], exp_val_q[i]);
      check({tag, " err cycle"}, cyc_q[i], exp_cyc_q[i]);
    end
  endtask

  task automatic randomize_file();
    for (int p = 0; p < 32; p++) begin
      m_opc[p] = 4'($urandom_range(0, 9));
      m_a[p] = $urandom;
      if ($urandom_range(0, 3) == 0) m_a[p] = $urandom_range(0, 20) - 10;
      m_b[p] = $urandom;
      if ($urandom_range(0, 3) == 0) m_b[p] = $urandom_range(0, 6) - 3;
      if ($urandom_range(0, 3) != 0) m_res[p] = ref_value(m_opc[p], m_a[p], m_b[p]);
      else m_res[p] = {$urandom, $urandom};
    end
  endtask

  initial begin
    for (int p = 0; p < 32; p++) set_entry(p, 0, 0, 0, 0);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    set_entry(0, 3, 5, 3, 8);
    set_entry(1, 4, 2, 7, -5);
    set_entry(2, 5, -4, 6, -24);
    set_entry(3, 2, 9, -1, -1);
    run("basic", 0, 4, 1'b0);

    set_entry(5, 6, 7, 0, 0);
    set_entry(6, 7, -7, 2, -1);
    set_entry(7, 6, -7, 2, -3);
    run("divmod", 5, 3, 1'b0);

    set_entry(2, 3, 1, 1, 3);
    run("mismatch", 2, 1, 1'b0);
    set_entry(2, 5, -4, 6, -24);

    set_entry(9, 11, 1, 2, 0);
    set_entry(10, 5, 32'h8000_0000, -1, 64'h0000_0000_8000_0000);
    run("badopc_mult", 9, 2, 1'b0);

    set_entry(30, 1, -3, 0, -3);
    set_entry(31, 0, 4, 4, 0);
    run("wrap", 30, 4, 1'b0);

    run("empty", 4, 0, 1'b0);
    run("busy_start", 0, 4, 1'b1);

    // Abort during the third entry's compare cycle.
    @(negedge clk);
    start = 1'b1;
    first_ptr = 5'd0;
    num_entries = 6'd4;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start = 1'b0;
    end
    check("pre-abort pass_count", pass_count, 2);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no done", done, 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle after abort", {busy, done}, 0);
    end
    run("after_abort", 0, 4, 1'b0);

    randomize_file();
    run("clamp", 17, 40, 1'b0);
    for (int r = 0; r < 6; r++) begin
      randomize_file();
      run("random", $urandom_range(0, 31), $urandom_range(0, 40), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_result_checker.md
INSTR_RESULT_CHECKER -- requirements
Module: instr_result_checker

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  one-cycle request to begin a check run; sampled only in IDLE.
REQ-004 SHALL have ports: first_ptr  in  5  first register-file entry to check.
REQ-005 SHALL have ports: num_entries  in  6  entries to check, 0..32; sampled with start.
REQ-006 SHALL have ports: read_pointer  out  5  address driven to the instruction register file (registered).
REQ-007 SHALL have ports: iw_opc  in  4  opcode of the addressed entry (ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7).
REQ-008 SHALL have ports: iw_op_a, iw_op_b  in  32 each  signed operands of the addressed entry.
REQ-009 SHALL have ports: iw_result  in  64  signed stored result of the addressed entry.
REQ-010 SHALL have ports: busy  out  1  high from the cycle after accepted start until done.
REQ-011 SHALL have ports: done  out  1  one-cycle pulse at end of run.
REQ-012 SHALL have ports: pass_count, fail_count  out  6 each  entries matched / mismatched in current run.
REQ-013 SHALL have ports: err_valid  out  1  one-cycle pulse per mismatch; err_ptr  out  5; err_expected  out  64  expected value of the failing entry.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, CHECK, FINISH.
REQ-015 IDLE + start: SHALL load read_pointer<=first_ptr, remaining<=num_entries, clear pass_count/fail_count, go FETCH (or FINISH if num_entries==0).
REQ-016 FETCH (1 cycle): read-file data is combinational from read_pointer; SHALL capture iw_opc, iw_op_a, iw_op_b, iw_result into internal registers at end of cycle, go CHECK.
REQ-017 CHECK (1 cycle): SHALL compare captured result with expected, update counts, read_pointer<=read_pointer+1 (mod 32, wraps 31->0), remaining<=remaining-1; go FINISH if remaining==1 else FETCH.
REQ-018 Throughput SHALL be exactly 2 cycles per entry; start-to-done latency = 2*N+2 cycles (N>0), 2 cycles for N=0.
REQ-019 FINISH: SHALL pulse done for one cycle, return IDLE; counts hold until next accepted start.
REQ-020 Expected value SHALL be computed in 64-bit signed: ZERO->0; PASSA->sext(a); PASSB->sext(b); ADD->a+b; SUB->a-b; MULT->full 64-bit product a*b.
REQ-021 DIV SHALL yield 0 when b==0, else a/b truncated toward zero; MOD SHALL yield 0 when b==0, else remainder with sign of a.
REQ-022 Opcode values 8..15 SHALL count as fail with err_expected=0.
REQ-023 On mismatch SHALL pulse err_valid in the cycle after CHECK with err_ptr = checked address and err_expected.
REQ-024 start while not in IDLE SHALL be ignored; num_entries>32 SHALL be clamped to 32.
REQ-025 pass_count+fail_count SHALL equal entries checked; counts SHALL never wrap.

Reset
REQ-026 reset_n low SHALL force, asynchronously: state IDLE, read_pointer=0, busy=0, done=0, err_valid=0, pass_count=0, fail_count=0, err_ptr=0, err_expected=0, captured registers 0.
REQ-027 Reset mid-run SHALL abort the run with no done pulse; first start after release begins a fresh run.

Verification
REQ-028 Scenario: entries 0..3 = ADD(5,3,8), SUB(2,7,-5), MULT(-4,6,-24), PASSB(9,-1,-1); start first_ptr=0 num=4 -> pass=4 fail=0, done at cycle 10 after start, no err_valid.
REQ-029 Scenario: entry 5 = DIV(7,0,0), entry 6 = MOD(-7,2,-1), entry 7 = DIV(-7,2,-3); start first_ptr=5 num=3 -> pass=3.
REQ-030 Scenario: entry 2 = ADD(1,1,3) -> fail=1, err_valid pulse with err_ptr=2, err_expected=2.
REQ-031 Scenario: first_ptr=30 num=4 -> read_pointer sequence 30,31,0,1; done after 10 cycles.
REQ-032 Scenario: num=0 -> done 2 cycles after start, counts 0; start asserted while busy -> no restart, counts unaffected.
REQ-033 Scenario: reset_n asserted during CHECK of 3rd entry -> all outputs zero immediately, no done; subsequent run completes correctly.
